pbl_arbiter: RTL and testbench
==============================

// Module: pbl_arbiter
// PURPOSE
//  Parametrised first-press latch for N-player button games (tug-of-war and successors).
//  Synchronises and debounces every button, latches the first press (or a tie), and holds the
//  result until clr. Re-arms only after all buttons are released. Feeds the game-control FSM.
// PARAMETERS
//  N_PLAYERS        2   number of buttons/players, legal 2..16
//  SYNC_STAGES      2   synchroniser flops per button, legal 2..4
//  DEBOUNCE_CYCLES  4   consecutive stable cycles before the debounced level changes, legal >=1
//  CNT_W            8   per-player win-counter width (used only with PBL_WIN_COUNT_EN)
// PORTS
//  clk         in   1                     system clock, all flops rising edge
//  rst         in   1                     asynchronous, active-high reset
//  clr         in   1                     synchronous clear of the latched result
//  btn         in   N_PLAYERS             raw asynchronous buttons, 1 = pressed
//  push        out  1                     a result is latched
//  winner      out  N_PLAYERS             one-hot winner; multiple bits set on a tie
//  winner_idx  out  max(1,$clog2(N))      lowest set index of winner
//  tie         out  1                     more than one bit of winner is set
//  win_cnt     out  N_PLAYERS*CNT_W       per-player win counts (PBL_WIN_COUNT_EN only)
// BEHAVIOUR
//  - Reset (async): all flops 0; state ARMED; push=0, winner=0, winner_idx=0, tie=0, win_cnt=0.
//  - Input path per button: SYNC_STAGES-flop synchroniser, then debouncer. The debounced level
//    takes the synchronised value only after it has been stable DEBOUNCE_CYCLES consecutive cycles.
//  - Press event = rising edge of the debounced level (db & ~db_q). Releases never generate events.
//  - Latency: raw press held steady -> push high after exactly SYNC_STAGES+DEBOUNCE_CYCLES+1
//    clocks. With default parameters this is 7.
//  - The FSM has three states (ARMED, LATCHED, HOLDOFF). All outputs are registered.
//    ARMED:   any press event with clr=0 -> LATCHED. On that edge, winner <= event vector,
//             tie <= popcount>1, winner_idx <= lowest set index, push <= 1.
//    LATCHED: outputs held; all press events ignored. clr=1 -> HOLDOFF; outputs go to 0 on the
//             same edge.
//    HOLDOFF: when all debounced levels are 0 -> ARMED on the next edge. Press events are ignored.
//  - Simultaneous events: presses in the same cycle form a tie. There is no priority between
//    players. clr has priority over a press in the same cycle, so that press is discarded.
//  - A button held through reset produces a press event once its debounced level rises. This is
//    the defined behaviour.
//  - clr asserted in ARMED or HOLDOFF has no effect.
//  - rst asserted mid-operation aborts immediately. Debounce counters and synchronisers are
//    cleared.
// CONFIGURATION
//  - PBL_WIN_COUNT_EN defined: port win_cnt exists. There is one CNT_W counter per player,
//    incremented on the ARMED->LATCHED edge for every set bit of the new winner (a tie
//    increments all tied players). Counters saturate at 2**CNT_W-1, are not affected by clr,
//    and are cleared only by rst.
//  - PBL_WIN_COUNT_EN undefined: port win_cnt and its counters are absent. All other behaviour
//    is identical.
// STRUCTURE
//  - Package pbl_pkg contains the state enum (ARMED, LATCHED, HOLDOFF), the N_PLAYERS legal
//    limits, and a function for the winner_idx width.
//  - Sub-module pbl_debounce handles one button (synchroniser, stable counter, debounced level,
//    rise pulse). It is instantiated N_PLAYERS times via generate.
//  - The top level contains the FSM, the result registers, and the optional counters.
// TESTING (defaults: N_PLAYERS=4, SYNC=2, DEB=4)
//  - Single press: btn=4'b0100 held from cycle 0 -> push=1, winner=0100, winner_idx=2, tie=0
//    at cycle 7.
//  - Tie: btn[0] and btn[3] rise on the same edge -> winner=1001, tie=1, winner_idx=0.
//  - Bounce: btn[1] toggles every 2 cycles for 20 cycles, then stays 0 -> push stays 0
//    throughout.
//  - Late press: btn[2] press, then btn[1] press 1 cycle later -> winner=0100 only. clr with
//    both held -> outputs 0; no re-arm until both are released; a new press then latches.
//  - clr vs press: clr=1 on the same edge as the first press event in ARMED -> no latch;
//    push=0 next cycle.
//  - With PBL_WIN_COUNT_EN and CNT_W=2: player 1 wins 5 rounds -> win_cnt[1]=3 (saturated).
//    A tie of players 0 and 1 increments both. Async rst mid-round -> all outputs 0 with no
//    clock edge.

Source files
------------

// File: rtl/pbl_pkg.sv
// pbl_pkg: shared state encoding, player-count limits and index-width helper for pbl_arbiter
package pbl_pkg;
  typedef enum logic [1:0] {ARMED, LATCHED, HOLDOFF} pbl_state_t;
  localparam int N_PLAYERS_MIN = 2;
  localparam int N_PLAYERS_MAX = 16;
  function automatic int idx_w(input int n);
    return n > 2 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/pbl_debounce.sv
// pbl_debounce: one button -- synchroniser, stable-cycle counter, debounced level and rise pulse
module pbl_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic db,
  output logic rise
);
  localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0] cnt;
  logic db_q;
  // db follows the synchronised level once it has disagreed for DEBOUNCE_CYCLES edges in a row
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync <= '0;
      cnt  <= '0;
      db   <= 1'b0;
      db_q <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
      db_q <= db;
      if (sync[SYNC_STAGES-1] == db) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES-1)) begin
        cnt <= '0;
        db  <= ~db;
      end else cnt <= cnt + CW'(1);
    end
  assign rise = db & ~db_q;
endmodule

// File: rtl/pbl_arbiter.sv
// pbl_arbiter: first-press latch for N-player button games; PBL_WIN_COUNT_EN adds per-player win counters
module pbl_arbiter
  import pbl_pkg::*;
#(
  parameter int N_PLAYERS       = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               clr,
  input  logic [N_PLAYERS-1:0]               btn,
  output logic                               push,
  output logic [N_PLAYERS-1:0]               winner,
  output logic [idx_w(N_PLAYERS)-1:0]        winner_idx,
  output logic                               tie
`ifdef PBL_WIN_COUNT_EN
  ,output logic [N_PLAYERS*CNT_W-1:0]        win_cnt
`endif
);
  localparam int IW = idx_w(N_PLAYERS);
  pbl_state_t state;
  logic [N_PLAYERS-1:0] db, ev;
  logic [IW-1:0] lo;
  logic take;
  for (genvar i = 0; i < N_PLAYERS; i++) begin : g_btn
    pbl_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk (clk),
      .rst (rst),
      .raw (btn[i]),
      .db  (db[i]),
      .rise(ev[i])
    );
  end
  // lowest index among this cycle's press events
  always_comb begin
    lo = '0;
    for (int i = N_PLAYERS-1; i >= 0; i--) if (ev[i]) lo = IW'(i);
  end
  assign take = (state == ARMED) && (|ev) && !clr;
  // arbitration FSM with registered result; clr wins over a same-cycle press
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= ARMED;
      push       <= 1'b0;
      winner     <= '0;
      winner_idx <= '0;
      tie        <= 1'b0;
    end else case (state)
      ARMED: if (take) begin
        state      <= LATCHED;
        push       <= 1'b1;
        winner     <= ev;
        winner_idx <= lo;
        tie        <= |(ev & (ev - N_PLAYERS'(1)));
      end
      LATCHED: if (clr) begin
        state      <= HOLDOFF;
        push       <= 1'b0;
        winner     <= '0;
        winner_idx <= '0;
        tie        <= 1'b0;
      end
      HOLDOFF: if (!(|db)) state <= ARMED;
      default: state <= ARMED;
    endcase
`ifdef PBL_WIN_COUNT_EN
  // saturating per-player win counters; every tied player scores, clr leaves them alone
  always_ff @(posedge clk or posedge rst)
    if (rst) win_cnt <= '0;
    else if (take)
      for (int i = 0; i < N_PLAYERS; i++)
        if (ev[i] && win_cnt[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})
          win_cnt[i*CNT_W +: CNT_W] <= win_cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
`endif
endmodule

// File: tb/tb_pbl_arbiter.sv
// tb_pbl_arbiter: randomized and directed checks of pbl_arbiter against a stable-window reference model
module tb_pbl_arbiter;
  localparam int N  = 4;
  localparam int S  = 2;
  localparam int D  = 4;
  localparam int CW = 2;
  logic clk = 1'b0, rst = 1'b0, clr = 1'b0;
  logic [N-1:0] btn = '0;
  logic push, tie;
  logic [N-1:0] winner;
  logic [1:0] winner_idx;
`ifdef PBL_WIN_COUNT_EN
  logic [N*CW-1:0] win_cnt;
`endif
  int n_chk = 0, n_pass = 0, n_fail = 0;
  logic [N-1:0] hist[$];
  logic [N-1:0] mdb, mdb_prev, mwin;
  logic mpush, mtie;
  logic [1:0] midx;
  int mst;
  int mcnt[N];

  always #5 clk = ~clk;

  pbl_arbiter #(.N_PLAYERS(N), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .btn       (btn),
    .push      (push),
    .winner    (winner),
    .winner_idx(winner_idx),
    .tie       (tie)
`ifdef PBL_WIN_COUNT_EN
    ,.win_cnt  (win_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end else n_pass++;
  endtask

  task automatic chk_outputs(input string tag);
`ifdef PBL_WIN_COUNT_EN
    logic [N*CW-1:0] ec;
`endif
    chk({tag, ".push"}, 32'(push), 32'(mpush));
    chk({tag, ".winner"}, 32'(winner), 32'(mwin));
    chk({tag, ".idx"}, 32'(winner_idx), 32'(midx));
    chk({tag, ".tie"}, 32'(tie), 32'(mtie));
`ifdef PBL_WIN_COUNT_EN
    for (int i = 0; i < N; i++) ec[i*CW +: CW] = CW'(mcnt[i]);
    chk({tag, ".win_cnt"}, 32'(win_cnt), 32'(ec));
`endif
  endtask

  task automatic model_reset();
    hist.delete();
    repeat (S + D) hist.push_back('0);
    mdb = '0; mdb_prev = '0; mwin = '0; mpush = 1'b0; mtie = 1'b0; midx = '0; mst = 0;
    for (int i = 0; i < N; i++) mcnt[i] = 0;
  endtask

  // assert async reset between edges, check outputs before any edge, release on a falling edge
  task automatic rst_dut();
    rst = 1'b1;
    clr = 1'b0;
    model_reset();
    #1;
    chk_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // one clock: drive inputs, advance the model, compare on the falling edge
  task automatic tick(input logic [N-1:0] b, input logic c);
    logic [N-1:0] ev, nd;
    logic found, all1, all0;
    btn = b;
    clr = c;
    @(posedge clk);
    ev = mdb & ~mdb_prev;
    if (mst == 0) begin
      if (ev != 0 && !c) begin
        mst = 1; mpush = 1'b1; mwin = ev; mtie = $countones(ev) > 1;
        found = 1'b0;
        for (int i = 0; i < N; i++) if (ev[i] && !found) begin midx = 2'(i); found = 1'b1; end
        for (int i = 0; i < N; i++) if (ev[i] && mcnt[i] < (1 << CW) - 1) mcnt[i]++;
      end
    end else if (mst == 1) begin
      if (c) begin mst = 2; mpush = 1'b0; mwin = '0; midx = '0; mtie = 1'b0; end
    end else if (mdb == 0) mst = 0;
    hist.push_back(b);
    if (hist.size() > S + D) void'(hist.pop_front());
    nd = mdb;
    for (int i = 0; i < N; i++) begin
      all1 = 1'b1; all0 = 1'b1;
      for (int j = 0; j < D; j++) begin all1 &= hist[j][i]; all0 &= !hist[j][i]; end
      if (all1) nd[i] = 1'b1; else if (all0) nd[i] = 1'b0;
    end
    mdb_prev = mdb;
    mdb = nd;
    @(negedge clk);
    chk_outputs("tick");
  endtask

  task automatic finish_round();
    tick('0, 1'b1);
    repeat (10) tick('0, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_dut();
    repeat (3) tick('0, 1'b0);
    // single press: result exactly 7 clocks after the raw press
    repeat (6) tick(4'b0100, 1'b0);
    chk("single.lat6", 32'(push), 32'd0);
    tick(4'b0100, 1'b0);
    chk("single.lat7", 32'(push), 32'd1);
    chk("single.winner", 32'(winner), 32'h4);
    chk("single.idx", 32'(winner_idx), 32'd2);
    chk("single.tie", 32'(tie), 32'd0);
    finish_round();
    // tie of players 0 and 3
    repeat (7) tick(4'b1001, 1'b0);
    chk("tie.winner", 32'(winner), 32'h9);
    chk("tie.tie", 32'(tie), 32'd1);
    chk("tie.idx", 32'(winner_idx), 32'd0);
    finish_round();
    // bouncing button never latches
    for (int i = 0; i < 20; i++) begin
      tick(((i / 2) % 2) != 0 ? 4'b0000 : 4'b0010, 1'b0);
      chk("bounce.push", 32'(push), 32'd0);
    end
    repeat (8) begin
      tick('0, 1'b0);
      chk("bounce.tail", 32'(push), 32'd0);
    end
    // late press loses; clr with both held, no re-arm until released
    tick(4'b0100, 1'b0);
    repeat (8) tick(4'b0110, 1'b0);
    chk("late.winner", 32'(winner), 32'h4);
    chk("late.idx", 32'(winner_idx), 32'd2);
    tick(4'b0110, 1'b1);
    chk("late.clr_push", 32'(push), 32'd0);
    chk("late.clr_winner", 32'(winner), 32'd0);
    repeat (10) tick(4'b0110, 1'b0);
    chk("late.held", 32'(push), 32'd0);
    repeat (10) tick('0, 1'b0);
    repeat (7) tick(4'b0010, 1'b0);
    chk("late.rearm_push", 32'(push), 32'd1);
    chk("late.rearm_winner", 32'(winner), 32'h2);
    finish_round();
    // clr on the same edge as the first press event discards it
    repeat (6) tick(4'b0001, 1'b0);
    tick(4'b0001, 1'b1);
    chk("clrpress.push", 32'(push), 32'd0);
    repeat (4) tick(4'b0001, 1'b0);
    chk("clrpress.hold", 32'(push), 32'd0);
    repeat (10) tick('0, 1'b0);
    // player 1 wins five rounds, then a tie of players 0 and 1
    repeat (5) begin
      repeat (8) tick(4'b0010, 1'b0);
      finish_round();
    end
`ifdef PBL_WIN_COUNT_EN
    chk("cnt.sat1", 32'(win_cnt[3:2]), 32'd3);
`endif
    repeat (8) tick(4'b0011, 1'b0);
    chk("tie01.winner", 32'(winner), 32'h3);
`ifdef PBL_WIN_COUNT_EN
    chk("cnt.tie0", 32'(win_cnt[1:0]), 32'd2);
    chk("cnt.tie1", 32'(win_cnt[3:2]), 32'd3);
`endif
    // asynchronous reset mid-round clears everything without a clock edge
    chk("abort.pre", 32'(push), 32'd1);
    rst_dut();
    // randomized play: random button patterns and hold lengths, occasional clr
    for (int s = 0; s < 150; s++) begin
      logic [N-1:0] b;
      int len;
      b = N'($urandom_range(0, 15));
      len = $urandom_range(1, 12);
      for (int k = 0; k < len; k++) tick(b, $urandom_range(0, 5) == 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
